ahb_dec_mux_n: RTL and testbench

//  N-slave AHB-Lite address decoder and response mux; replaces the fixed 4-slave decoder.

---
 rtl/ahb_dec_mux_n_pkg.sv | 30 +++
 rtl/ahb_dec_mux_n_if.sv | 31 +++
 rtl/ahb_dec_mux_n_default_slave.sv | 100 ++++++++++
 rtl/ahb_dec_mux_n.sv | 122 ++++++++++++
 tb/tb_ahb_dec_mux_n.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_dec_mux_n_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
//   htrans_t    : HTRANS transfer-type encodings
//   hresp_t     : HRESP response encodings
//   def_state_t : default (unmapped) slave FSM states
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    DEF_IDLE,
    DEF_ERR1,
    DEF_ERR2
  } def_state_t;

  // NONSEQ and SEQ are the only transfer types that need a real response.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_dec_mux_n_if.sv
// Bus bundle between the AHB master, the decoder/mux and the N slaves.
//   haddr_i/htrans_i          : address phase from the master
//   hsel_o                    : per-slave select
//   slv_hrdata_i/hresp_i/...  : packed slave responses, slot i = slave i
//   hrdata_o/hresp_o/hready_o : muxed response to the master (hready_o also slave HREADY)
// Modport slave is the decoder's view; master is the surrounding system's view.
interface ahb_dec_mux_n_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4
);
  logic [ADDR_WIDTH-1:0]            haddr_i;
  logic [1:0]                       htrans_i;
  logic [NUM_SLAVES-1:0]            hsel_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_hrdata_i;
  logic [NUM_SLAVES-1:0]            slv_hresp_i;
  logic [NUM_SLAVES-1:0]            slv_hreadyout_i;
  logic [DATA_WIDTH-1:0]            hrdata_o;
  logic                             hresp_o;
  logic                             hready_o;

  modport slave (
    input  haddr_i, htrans_i, slv_hrdata_i, slv_hresp_i, slv_hreadyout_i,
    output hsel_o, hrdata_o, hresp_o, hready_o
  );

  modport master (
    output haddr_i, htrans_i, slv_hrdata_i, slv_hresp_i, slv_hreadyout_i,
    input  hsel_o, hrdata_o, hresp_o, hready_o
  );
endinterface

// File: rtl/ahb_dec_mux_n_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response for active
// transfers, zero-wait OKAY for IDLE/BUSY, plus capture of the last failing
// address and a saturating error counter.
//   accept_i       : address phase accepted this cycle (bus hready)
//   unmapped_act_i : current address phase is unmapped and NONSEQ/SEQ
//   haddr_i        : current address, captured on error entry
//   err_clr_i      : synchronous clear of the counter
//   hready_o/hresp_o : data-phase response when the default slave is selected
//   busy_o         : FSM is in an error response
//   err_addr_o/err_cnt_o : error capture registers
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     accept_i,
  input  logic                     unmapped_act_i,
  input  logic [ADDR_WIDTH-1:0]    haddr_i,
  input  logic                     err_clr_i,
  output logic                     hready_o,
  output logic                     hresp_o,
  output logic                     busy_o,
  output logic [ADDR_WIDTH-1:0]    err_addr_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

  def_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]    err_addr_q, err_addr_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     entry;

  // Outputs depend on state only; kept apart from next-state logic so the
  // hready -> accept path back into this module is not a combinational loop.
  always_comb begin
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    unique case (state_q)
      DEF_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
      end
      DEF_ERR2: hresp_o = HRESP_ERROR;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    entry   = 1'b0;
    unique case (state_q)
      DEF_IDLE: begin
        if (accept_i && unmapped_act_i) begin
          state_d = DEF_ERR1;
          entry   = 1'b1;
        end
      end
      DEF_ERR1: state_d = DEF_ERR2;
      DEF_ERR2: begin
        if (accept_i && unmapped_act_i) begin
          state_d = DEF_ERR1;
          entry   = 1'b1;
        end else begin
          state_d = DEF_IDLE;
        end
      end
      default: state_d = DEF_IDLE;
    endcase

    err_addr_d = entry ? haddr_i : err_addr_q;

    // A clear coinciding with a new error leaves exactly that one error counted.
    err_cnt_d = err_cnt_q;
    if (entry) begin
      if (err_clr_i)        err_cnt_d = ERR_CNT_WIDTH'(1);
      else if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end else if (err_clr_i) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DEF_IDLE;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign busy_o     = (state_q != DEF_IDLE);
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/ahb_dec_mux_n.sv
// N-slave AHB-Lite address decoder and response mux with an integrated
// default slave for unmapped addresses.
//   hclk_i/hrst_i : clock, async active-high reset
//   bus           : address phase in, hsel out, slave responses in, muxed response out
//   err_addr_o    : address of the last unmapped active transfer
//   err_cnt_o     : saturating count of unmapped active transfers
//   err_clr_i     : synchronous clear of err_cnt_o
// Region i hits when (haddr & SLV_MASK[i]) == SLV_BASE[i]; lowest index wins.
module ahb_dec_mux_n
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_SLAVES    = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
    {32'h03000000, 32'h02000000, 32'h01000000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {4{32'hFF000000}},
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     hclk_i,
  input  logic                     hrst_i,
  ahb_dec_mux_n_if.slave           bus,
  output logic [ADDR_WIDTH-1:0]    err_addr_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  input  logic                     err_clr_i
);

  localparam int unsigned DSEL_W = $clog2(NUM_SLAVES + 1);
  localparam logic [DSEL_W-1:0] DEF = DSEL_W'(NUM_SLAVES);

  logic [NUM_SLAVES-1:0] hit;
  logic [NUM_SLAVES-1:0] hsel;
  logic [DSEL_W-1:0]     win;
  logic                  found;

  logic [DSEL_W-1:0]     dsel_q, dsel_d;
  logic                  def_act_q, def_act_d;

  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hresp, hready;
  logic                  def_hready, def_hresp, def_busy;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_dec
    assign hit[i] = (bus.haddr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                    == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    hsel  = '0;
    win   = DEF;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (hit[i] && !found) begin
        found   = 1'b1;
        hsel[i] = 1'b1;
        win     = DSEL_W'(i);
      end
    end
  end

  always_comb begin
    dsel_d    = dsel_q;
    def_act_d = def_act_q;
    if (hready) begin
      dsel_d    = win;
      def_act_d = !found && is_active(bus.htrans_i);
    end
  end

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      dsel_q    <= DEF;
      def_act_q <= 1'b0;
    end else begin
      dsel_q    <= dsel_d;
      def_act_q <= def_act_d;
    end
  end

  // Data-phase mux driven solely by the registered selection.
  always_comb begin
    hrdata = '0;
    hresp  = def_hresp;
    hready = def_hready;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == DSEL_W'(i)) begin
        hrdata = bus.slv_hrdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        hresp  = bus.slv_hresp_i[i];
        hready = bus.slv_hreadyout_i[i];
      end
    end
  end

  ahb_default_slave #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_def (
    .clk           (hclk_i),
    .rst           (hrst_i),
    .accept_i      (hready),
    .unmapped_act_i(!found && is_active(bus.htrans_i)),
    .haddr_i       (bus.haddr_i),
    .err_clr_i     (err_clr_i),
    .hready_o      (def_hready),
    .hresp_o       (def_hresp),
    .busy_o        (def_busy),
    .err_addr_o    (err_addr_o),
    .err_cnt_o     (err_cnt_o)
  );

  // An accepted unmapped active transfer keeps the default slave busy until
  // the next accept, so the two views of "error in progress" must agree.
  a_def_act_consistent: assert property (
    @(posedge hclk_i) disable iff (hrst_i) def_act_q == def_busy
  );

  assign bus.hsel_o   = hsel;
  assign bus.hrdata_o = hrdata;
  assign bus.hresp_o  = hresp;
  assign bus.hready_o = hready;

endmodule

// File: tb/tb_ahb_dec_mux_n.sv
module tb_ahb_dec_mux_n;
  import ahb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, err_clr;
  logic [31:0] err_addr, err_addr2;
  logic [7:0]  err_cnt, err_cnt2;

  logic [31:0] sd [4];
  logic        sr [4];
  logic        sp [4];

  ahb_dec_mux_n_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4)) bus ();
  ahb_dec_mux_n_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(2)) bus2 ();

  assign bus.slv_hrdata_i    = {sd[3], sd[2], sd[1], sd[0]};
  assign bus.slv_hreadyout_i = {sr[3], sr[2], sr[1], sr[0]};
  assign bus.slv_hresp_i     = {sp[3], sp[2], sp[1], sp[0]};

  ahb_dec_mux_n #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .ERR_CNT_WIDTH(8)) dut (
    .hclk_i(clk), .hrst_i(rst), .bus(bus),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
  );

  ahb_dec_mux_n #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(2),
    .SLV_BASE({32'h00000000, 32'h00000000}),
    .SLV_MASK({2{32'hFF000000}}),
    .ERR_CNT_WIDTH(8)
  ) dut2 (
    .hclk_i(clk), .hrst_i(rst), .bus(bus2),
    .err_addr_o(err_addr2), .err_cnt_o(err_cnt2), .err_clr_i(1'b0)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: data-phase target (-1 = unmapped), error cycle (0 none, 1, 2).
  int          mdsel, merr, mcnt;
  logic [31:0] maddr;

  logic [3:0]  obs_sel;
  logic        obs_rdy, obs_resp;
  logic [31:0] obs_data;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  sel;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Default map: slave k owns 0x0k000000..0x0kFFFFFF for k in 0..3.
  function automatic int region(input logic [31:0] a);
    if (a[31:24] < 8'd4) return int'(a[31:24]);
    return -1;
  endfunction

  task automatic model_reset();
    mdsel = -1; merr = 0; mcnt = 0; maddr = '0;
  endtask

  // One bus cycle: apply address phase, check against model, advance model at the edge.
  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic clr);
    int r; logic er, ep; logic [31:0] ed; logic [3:0] es; bit entry;
    bus.haddr_i = a; bus.htrans_i = t; err_clr = clr;
    #1;
    r  = region(a);
    es = (r >= 0) ? 4'(1 << r) : 4'b0000;
    if (mdsel >= 0) begin
      er = sr[mdsel]; ep = sp[mdsel]; ed = sd[mdsel];
    end else begin
      er = (merr != 1); ep = (merr != 0); ed = '0;
    end
    obs_sel = bus.hsel_o; obs_rdy = bus.hready_o; obs_resp = bus.hresp_o; obs_data = bus.hrdata_o;
    chk("hsel", obs_sel, es);
    chk("hready", obs_rdy, er);
    chk("hresp", obs_resp, ep);
    chk("hrdata", obs_data, ed);
    chk("err_addr", err_addr, maddr);
    chk("err_cnt", err_cnt, mcnt);
    @(posedge clk);
    entry = 0;
    if (er) begin
      if (r >= 0) begin
        mdsel = r; merr = 0;
      end else begin
        mdsel = -1;
        if (t[1]) begin
          entry = 1; merr = 1; maddr = a;
          mcnt = clr ? 1 : ((mcnt == 255) ? 255 : mcnt + 1);
        end else begin
          merr = 0;
        end
      end
    end else if (merr == 1) begin
      merr = 2;
    end
    if (clr && !entry) mcnt = 0;
    #1;
  endtask

  task automatic do_reset();
    bus.haddr_i = '0; bus.htrans_i = HTRANS_IDLE; err_clr = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_async_hready", bus.hready_o, 1'b1);
    chk("rst_async_hresp", bus.hresp_o, 1'b0);
    chk("rst_async_hrdata", bus.hrdata_o, 32'h0);
    chk("rst_async_err_cnt", err_cnt, 8'h0);
    @(posedge clk);
    #1;
    chk("rst_hready", bus.hready_o, 1'b1);
    chk("rst_hresp", bus.hresp_o, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_cnt", err_cnt, 8'h0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    vt[0] = '{32'h00000000, HTRANS_NONSEQ, 4'b0001};
    vt[1] = '{32'h00FFFFFC, HTRANS_SEQ,    4'b0001};
    vt[2] = '{32'h01000010, HTRANS_NONSEQ, 4'b0010};
    vt[3] = '{32'h02ABCDEF, HTRANS_NONSEQ, 4'b0100};
    vt[4] = '{32'h03FFFFFF, HTRANS_IDLE,   4'b1000};
    vt[5] = '{32'h02000000, HTRANS_BUSY,   4'b0100};
    vt[6] = '{32'h04000000, HTRANS_IDLE,   4'b0000};
    vt[7] = '{32'hFF000000, HTRANS_NONSEQ, 4'b0000};
    vt[8] = '{32'h03000000, HTRANS_NONSEQ, 4'b1000};

    for (int i = 0; i < 4; i++) begin
      sr[i] = 1'b1; sp[i] = 1'b0; sd[i] = 32'h1000_0000 * (i + 1) + 32'h55;
    end
    bus2.haddr_i = '0; bus2.htrans_i = HTRANS_IDLE;
    bus2.slv_hrdata_i = '0; bus2.slv_hresp_i = '0; bus2.slv_hreadyout_i = '1;

    do_reset();

    // Reset asserted while the default slave is in its first error cycle.
    step(32'h05000000, HTRANS_NONSEQ, 1'b0);
    chk("pre_rst_err1_hready", bus.hready_o, 1'b0);
    chk("pre_rst_err1_cnt", err_cnt, 8'h01);
    do_reset();

    // Single read from slave 1.
    sd[1] = 32'hDEADBEEF;
    step(32'h01000010, HTRANS_NONSEQ, 1'b0);
    chk("rd_hsel", obs_sel, 4'b0010);
    step(32'h00000000, HTRANS_IDLE, 1'b0);
    chk("rd_data", obs_data, 32'hDEADBEEF);

    // Back-to-back with a two-cycle stall on slave 0.
    sd[0] = 32'hA0A0A0A0; sd[2] = 32'hC2C2C2C2;
    step(32'h00000000, HTRANS_NONSEQ, 1'b0);
    sr[0] = 1'b0;
    step(32'h02000004, HTRANS_NONSEQ, 1'b0);
    chk("stall1_hready", obs_rdy, 1'b0);
    chk("stall1_data", obs_data, 32'hA0A0A0A0);
    step(32'h02000004, HTRANS_NONSEQ, 1'b0);
    chk("stall2_hready", obs_rdy, 1'b0);
    sr[0] = 1'b1;
    step(32'h02000004, HTRANS_NONSEQ, 1'b0);
    chk("stall_done_data", obs_data, 32'hA0A0A0A0);
    step(32'h00000000, HTRANS_IDLE, 1'b0);
    chk("after_stall_data", obs_data, 32'hC2C2C2C2);

    // Unmapped active transfer: two-cycle ERROR; unmapped IDLE is OKAY.
    step(32'h05000000, HTRANS_NONSEQ, 1'b0);
    step(32'h00000000, HTRANS_IDLE, 1'b0);
    chk("err1_hready", obs_rdy, 1'b0);
    chk("err1_hresp", obs_resp, 1'b1);
    step(32'h00000000, HTRANS_IDLE, 1'b0);
    chk("err2_hready", obs_rdy, 1'b1);
    chk("err2_hresp", obs_resp, 1'b1);
    chk("err_addr_cap", err_addr, 32'h05000000);
    chk("err_cnt_one", err_cnt, 8'h01);
    step(32'h05000000, HTRANS_IDLE, 1'b0);
    step(32'h00000000, HTRANS_IDLE, 1'b0);
    chk("unmapped_idle_resp", obs_resp, 1'b0);
    chk("unmapped_idle_cnt", err_cnt, 8'h01);

    // New error accepted during ERR2.
    do_reset();
    step(32'h06000000, HTRANS_NONSEQ, 1'b0);
    step(32'h07000000, HTRANS_NONSEQ, 1'b0);
    step(32'h07000000, HTRANS_NONSEQ, 1'b0);
    chk("chain_err2_hready", obs_rdy, 1'b1);
    step(32'h00000000, HTRANS_IDLE, 1'b0);
    chk("chain_err1_again", obs_rdy, 1'b0);
    chk("chain_cnt", err_cnt, 8'h02);
    chk("chain_addr", err_addr, 32'h07000000);

    // Saturation.
    for (int i = 0; i < 600; i++) step(32'h0A000000, HTRANS_NONSEQ, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h00000000, HTRANS_IDLE, 1'b0);
    chk("cnt_saturated", err_cnt, 8'hFF);

    // Clear colliding with a new error entry, then a plain clear.
    step(32'h09000000, HTRANS_NONSEQ, 1'b1);
    chk("clr_with_entry", err_cnt, 8'h01);
    step(32'h00000000, HTRANS_IDLE, 1'b0);
    step(32'h00000000, HTRANS_IDLE, 1'b1);
    chk("clr_plain", err_cnt, 8'h00);

    // Decode table.
    for (int i = 0; i < 9; i++) begin
      step(vt[i].addr, vt[i].trans, 1'b0);
      chk($sformatf("tbl_hsel_%0d", i), obs_sel, vt[i].sel);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        sr[i] = ($urandom_range(0, 3) != 0);
        sp[i] = ($urandom_range(0, 7) == 0);
        sd[i] = $urandom;
      end
      step({8'($urandom_range(0, 6)), 24'($urandom)}, 2'($urandom_range(0, 3)),
           ($urandom_range(0, 31) == 0));
    end

    // Overlapping map on the two-slave instance: lowest index wins.
    bus2.haddr_i = 32'h00000040;
    #1;
    chk("overlap_hsel", bus2.hsel_o, 2'b01);
    bus2.haddr_i = 32'h01000000;
    #1;
    chk("overlap_miss_hsel", bus2.hsel_o, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
